// File: rtl/ysyx_23060236_imem_axi_slave.sv
// AXI4 read-only burst responder in front of a word-organised instruction
// memory, serving the IFU cache-line refill port.
//
//   state | meaning
//   IDLE  | arready high, waiting for an address handshake
//   WAIT  | access latency countdown before the first beat
//   BEAT  | rvalid high, current beat held until rready
//   GAP   | idle cycles between a beat handshake and the next beat
module ysyx_23060236_imem_axi_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter int          BEAT_GAP   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [1:0]  arburst,
  input  logic [3:0]  arlen,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic        ld_wen,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_GAP} state_e;

  state_e      state_q, state_d;
  logic [15:0] lat_q, gap_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q, beat_q;
  logic [1:0]  burst_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic [31:0] mem_q [DEPTH];

  logic        ar_hs, r_hs;
  logic [31:0] f_addr;
  logic [3:0]  f_len, f_beat;
  logic [1:0]  f_burst;
  logic        f_slverr, f_in_range;
  logic        load_beat, advance;

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 2;
    return off[DEPTH_LOG2-1:0];
  endfunction

  function automatic logic wrap_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  // WRAP container is (len+1)*4 bytes, so the wrapping mask is {len, 2'b11}
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [1:0] burst);
    logic [31:0] inc, mask;
    inc  = a + 32'd4;
    mask = {26'd0, len, 2'b11};
    case (burst)
      2'b00:   return a;
      2'b10:   return wrap_ok(len) ? ((a & ~mask) | (inc & mask)) : inc;
      default: return inc;
    endcase
  endfunction

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ar_hs) state_d = (LATENCY <= 1) ? S_BEAT : S_WAIT;
      S_WAIT: if (lat_q <= 16'd1) state_d = S_BEAT;
      S_BEAT: if (r_hs) begin
        if (rlast_q)           state_d = S_IDLE;
        else if (BEAT_GAP > 0) state_d = S_GAP;
        else                   state_d = S_BEAT;
      end
      S_GAP:  if (gap_q == 16'd0) state_d = S_BEAT;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; arready waits one edge after reset
  always_comb begin
    arready = (state_q == S_IDLE) && ready_q;
    rvalid  = (state_q == S_BEAT);
  end

  // Address/length/beat of the beat that would be fetched at this edge
  always_comb begin
    f_addr  = addr_q;
    f_len   = len_q;
    f_burst = burst_q;
    f_beat  = beat_q;
    case (state_q)
      S_IDLE: begin
        f_addr  = araddr & ~32'h3;
        f_len   = arlen;
        f_burst = arburst;
        f_beat  = 4'd0;
      end
      S_BEAT: begin
        f_addr = next_addr(addr_q, len_q, burst_q);
        f_beat = beat_q + 4'd1;
      end
      default: ;
    endcase
    f_slverr   = (f_burst == 2'b11) || ((f_burst == 2'b10) && !wrap_ok(f_len));
    f_in_range = in_range(f_addr);
    load_beat  = (state_d == S_BEAT) && ((state_q != S_BEAT) || r_hs);
    advance    = (state_q == S_BEAT) && r_hs && !rlast_q;
  end

  // Burst context, counters and the registered read-data channel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      lat_q   <= 16'd0;
      gap_q   <= 16'd0;
      addr_q  <= 32'd0;
      len_q   <= 4'd0;
      beat_q  <= 4'd0;
      burst_q <= 2'b00;
      rdata_q <= 32'd0;
      rresp_q <= 2'b00;
      rlast_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (ar_hs) begin
        addr_q  <= f_addr;
        len_q   <= arlen;
        burst_q <= arburst;
        beat_q  <= 4'd0;
        lat_q   <= 16'(LATENCY - 1);
      end
      if (state_q == S_WAIT) lat_q <= lat_q - 16'd1;
      if (advance) begin
        addr_q <= f_addr;
        beat_q <= f_beat;
        gap_q  <= 16'(BEAT_GAP - 1);
      end
      if ((state_q == S_GAP) && (gap_q != 16'd0)) gap_q <= gap_q - 16'd1;
      if (load_beat) begin
        rlast_q <= (f_beat == f_len);
        if (f_slverr) begin
          rresp_q <= 2'b10;
          rdata_q <= 32'd0;
        end else if (!f_in_range) begin
          rresp_q <= 2'b11;
          rdata_q <= 32'd0;
        end else begin
          rresp_q <= 2'b00;
          rdata_q <= mem_q[word_idx(f_addr)];
        end
      end else if ((state_q == S_BEAT) && r_hs && rlast_q) begin
        rlast_q <= 1'b0;
        rresp_q <= 2'b00;
        rdata_q <= 32'd0;
      end
    end
  end

  // Preload port; contents are not reset and out-of-range writes are dropped
  always_ff @(posedge clock) begin
    if (ld_wen && in_range(ld_addr)) mem_q[word_idx(ld_addr)] <= ld_wdata;
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rlast = rlast_q;

endmodule
